// File: rtl/ysyx_22050612_divw_seq_if.sv
// Operand/result handshake bundle for the sequential 32-bit divider (divw/divuw/remw/remuw).
// The driver side uses the master modport and the divider uses the slave modport.
interface ysyx_22050612_divw_seq_if;
    localparam int unsigned XLEN = 64;

    logic            in_valid;
    logic            in_ready;
    logic            op_rem;
    logic            op_unsigned;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            busy;

    modport master (
        output in_valid, op_rem, op_unsigned, src1, src2, kill, out_ready,
        input  in_ready, out_valid, result, busy
    );

    modport slave (
        input  in_valid, op_rem, op_unsigned, src1, src2, kill, out_ready,
        output in_ready, out_valid, result, busy
    );
endinterface

// File: rtl/ysyx_22050612_divw_seq.sv
// Sequential restoring divider for RV64 word divide/remainder, one quotient bit per cycle.
// Define YSYX_22050612_DIVW_EARLYOUT_EN to finish immediately when |dividend| < |divisor|.
module ysyx_22050612_divw_seq (
    input  logic                           clk,
    input  logic                           rst,
    ysyx_22050612_divw_seq_if.slave        io_div
);
    localparam int unsigned XLEN = 64;
    localparam int unsigned W    = 32;
    localparam int unsigned CNTW = 6;
    localparam logic [CNTW-1:0] LAST_ITER = CNTW'(W - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNTW-1:0]   r_cnt;
    logic [W-1:0]      r_divisor;
    logic [W-1:0]      r_part;
    logic [W-1:0]      r_quo;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_op_rem;
    logic [XLEN-1:0]   r_result;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic              w_accept;
    logic              w_handoff;
    logic [W-1:0]      w_a;
    logic [W-1:0]      w_b;
    logic              w_sign1;
    logic              w_sign2;
    logic [W-1:0]      w_mag_a;
    logic [W-1:0]      w_mag_b;
    logic              w_div_zero;
    logic              w_ovf;
    logic              w_early;
    logic [W:0]        w_shift;
    logic [W:0]        w_diff;
    logic              w_ge;
    logic [W-1:0]      w_part_nxt;
    logic [W-1:0]      w_quo_nxt;
    logic [XLEN-1:0]   w_res_nxt;
    logic              w_unused_hi;

    function automatic logic [XLEN-1:0] sext_w(input logic [W-1:0] v);
        return {{(XLEN-W){v[W-1]}}, v};
    endfunction

    // Apply the recorded signs to the raw magnitudes and pick quotient or remainder.
    function automatic logic [XLEN-1:0] fixup(input logic [W-1:0] q, input logic [W-1:0] r,
                                              input logic neg_q, input logic neg_r,
                                              input logic sel_rem);
        logic [W-1:0] q_s;
        logic [W-1:0] r_s;
        q_s = neg_q ? (~q + W'(1)) : q;
        r_s = neg_r ? (~r + W'(1)) : r;
        return sext_w(sel_rem ? r_s : q_s);
    endfunction

    assign w_unused_hi = &{1'b0, io_div.src1[XLEN-1:W], io_div.src2[XLEN-1:W]};

    assign w_accept  = io_div.in_valid & r_in_ready & ~io_div.kill;
    assign w_handoff = r_out_valid & io_div.out_ready;

    assign w_a        = io_div.src1[W-1:0];
    assign w_b        = io_div.src2[W-1:0];
    assign w_sign1    = ~io_div.op_unsigned & w_a[W-1];
    assign w_sign2    = ~io_div.op_unsigned & w_b[W-1];
    assign w_mag_a    = w_sign1 ? (~w_a + W'(1)) : w_a;
    assign w_mag_b    = w_sign2 ? (~w_b + W'(1)) : w_b;
    assign w_div_zero = (w_b == '0);
    assign w_ovf      = ~io_div.op_unsigned & (w_a == 32'h8000_0000) & (w_b == 32'hFFFF_FFFF);

`ifdef YSYX_22050612_DIVW_EARLYOUT_EN
    assign w_early = ~w_div_zero & (w_mag_a < w_mag_b);
`else
    assign w_early = 1'b0;
`endif

    // One restoring step: shift in the next dividend bit and subtract if it fits.
    assign w_shift    = {r_part, r_quo[W-1]};
    assign w_diff     = w_shift - {1'b0, r_divisor};
    assign w_ge       = (w_shift >= {1'b0, r_divisor});
    assign w_part_nxt = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
    assign w_quo_nxt  = {r_quo[W-2:0], w_ge};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_res_nxt   = r_result;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (w_div_zero) begin
                        w_state_nxt = DONE;
                        w_res_nxt   = sext_w(io_div.op_rem ? w_a : 32'hFFFF_FFFF);
                    end else if (w_ovf) begin
                        w_state_nxt = DONE;
                        w_res_nxt   = io_div.op_rem ? '0 : sext_w(32'h8000_0000);
                    end else if (w_early) begin
                        w_state_nxt = DONE;
                        w_res_nxt   = io_div.op_rem ? sext_w(w_a) : '0;
                    end else begin
                        w_state_nxt = CALC;
                    end
                end
            end
            CALC: begin
                if (r_cnt == LAST_ITER) begin
                    w_state_nxt = DONE;
                    w_res_nxt   = fixup(w_quo_nxt, w_part_nxt, r_neg_q, r_neg_r, r_op_rem);
                end
            end
            DONE: begin
                if (w_handoff) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (io_div.kill) begin
            w_state_nxt = IDLE;
            w_res_nxt   = '0;
        end
    end

    // Datapath and registered handshake outputs follow the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_divisor   <= '0;
            r_part      <= '0;
            r_quo       <= '0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_op_rem    <= 1'b0;
            r_result    <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            r_busy      <= (w_state_nxt != IDLE);
            r_result    <= w_res_nxt;
            if (io_div.kill) begin
                r_cnt <= '0;
            end else if (r_state == IDLE && w_accept) begin
                r_cnt     <= '0;
                r_divisor <= w_mag_b;
                r_part    <= '0;
                r_quo     <= w_mag_a;
                r_neg_q   <= w_sign1 ^ w_sign2;
                r_neg_r   <= w_sign1;
                r_op_rem  <= io_div.op_rem;
            end else if (r_state == CALC) begin
                r_part <= w_part_nxt;
                r_quo  <= w_quo_nxt;
                r_cnt  <= (r_cnt == LAST_ITER) ? '0 : r_cnt + CNTW'(1);
            end
        end
    end

    assign io_div.in_ready  = r_in_ready;
    assign io_div.out_valid = r_out_valid;
    assign io_div.busy      = r_busy;
    assign io_div.result    = r_result;
endmodule

// File: tb/tb_ysyx_22050612_divw_seq.sv
// Scoreboard bench for the sequential word divider: directed corner cases plus random operands
// checked against a plain-arithmetic reference; honours YSYX_22050612_DIVW_EARLYOUT_EN for latency.
module tb_ysyx_22050612_divw_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ysyx_22050612_divw_seq_if bus ();

    ysyx_22050612_divw_seq dut (
        .clk    (clk),
        .rst    (rst),
        .io_div (bus.slave)
    );

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          acc_cyc;
        int          hold;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: RISC-V word divide semantics using native integer arithmetic.
    function automatic logic [63:0] ref_res(input logic [63:0] s1, input logic [63:0] s2,
                                            input bit rem, input bit uns);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] v;
        int sa;
        int sb;
        a = s1[31:0];
        b = s2[31:0];
        if (b == 32'd0) v = rem ? a : 32'hFFFF_FFFF;
        else if (uns) v = rem ? (a % b) : (a / b);
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) v = rem ? 32'd0 : 32'h8000_0000;
        else begin
            sa = $signed(a);
            sb = $signed(b);
            v  = rem ? 32'(sa % sb) : 32'(sa / sb);
        end
        return {{32{v[31]}}, v};
    endfunction

    function automatic int ref_lat(input logic [63:0] s1, input logic [63:0] s2, input bit uns);
        longint ma;
        longint mb;
        longint sa;
        longint sb;
        sa = longint'($signed(s1[31:0]));
        sb = longint'($signed(s2[31:0]));
        ma = uns ? longint'({32'd0, s1[31:0]}) : (sa < 0 ? -sa : sa);
        mb = uns ? longint'({32'd0, s2[31:0]}) : (sb < 0 ? -sb : sb);
        if (s2[31:0] == 32'd0) return 1;
        if (!uns && s1[31:0] == 32'h8000_0000 && s2[31:0] == 32'hFFFF_FFFF) return 1;
`ifdef YSYX_22050612_DIVW_EARLYOUT_EN
        if (ma < mb) return 1;
`endif
        return 33;
    endfunction

    // Offer one operand set and, if requested, record what the scoreboard must see.
    task automatic issue(input logic [63:0] s1, input logic [63:0] s2, input bit rem,
                         input bit uns, input int hold, input logic [63:0] eres,
                         input int elat, input bit push);
        int n;
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b1;
        bus.src1        = s1;
        bus.src2        = s2;
        bus.op_rem      = rem;
        bus.op_unsigned = uns;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("accept_timeout", 64'(bus.in_ready), 64'd1);
        if (push) exp_q.push_back('{eres, elat, cyc + 1, hold});
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.src1        = {$urandom, $urandom};
        bus.src2        = {$urandom, $urandom};
        bus.op_rem      = $urandom_range(0, 1);
        bus.op_unsigned = $urandom_range(0, 1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_op(input logic [63:0] s1, input logic [63:0] s2, input bit rem,
                          input bit uns, input int hold);
        issue(s1, s2, rem, uns, hold, ref_res(s1, s2, rem, uns), ref_lat(s1, s2, uns), 1'b1);
        wait_idle();
    endtask

    // Monitor and consumer: pops on the first valid cycle, then checks hold stability.
    initial begin : monitor
        exp_t cur;
        bit   in_done;
        int   hold_left;
        in_done       = 1'b0;
        hold_left     = 0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_done       = 1'b0;
                bus.out_ready = 1'b0;
            end else if (bus.out_valid) begin
                if (!in_done) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", 64'(bus.out_valid), 64'd0);
                        cur = '{64'd0, 0, 0, 0};
                    end else begin
                        cur = exp_q.pop_front();
                        chk("result", bus.result, cur.res);
                        chk("latency", 64'(cyc - cur.acc_cyc + 1), 64'(cur.lat));
                    end
                    in_done   = 1'b1;
                    hold_left = cur.hold;
                end else begin
                    chk("result_hold", bus.result, cur.res);
                end
                chk("in_ready_done", 64'(bus.in_ready), 64'd0);
                chk("busy_done", 64'(bus.busy), 64'd1);
                if (hold_left > 0) begin
                    bus.out_ready = 1'b0;
                    hold_left--;
                end else begin
                    bus.out_ready = 1'b1;
                    in_done       = 1'b0;
                end
            end else begin
                bus.out_ready = 1'b0;
                in_done       = 1'b0;
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    endtask

    typedef struct {
        logic [63:0] s1;
        logic [63:0] s2;
        bit          rem;
        bit          uns;
        int          hold;
        logic [63:0] eres;
    } dir_t;

    initial begin : stim
        dir_t dir[$];
        logic [63:0] s1;
        logic [63:0] s2;
        int          sel;
        int          early_lat;

        bus.in_valid    = 1'b0;
        bus.op_rem      = 1'b0;
        bus.op_unsigned = 1'b0;
        bus.src1        = '0;
        bus.src2        = '0;
        bus.kill        = 1'b0;
        rst             = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        chk("reset_result", bus.result, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        dir.push_back('{64'd100, 64'd7, 1'b0, 1'b0, 0, 64'h0000_0000_0000_000E});
        dir.push_back('{64'd100, 64'd7, 1'b1, 1'b0, 0, 64'h0000_0000_0000_0002});
        dir.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b0, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFD});
        dir.push_back('{64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 1'b1, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF});
        dir.push_back('{64'd5, 64'd0, 1'b0, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFF});
        dir.push_back('{64'd5, 64'd0, 1'b1, 1'b0, 0, 64'h0000_0000_0000_0005});
        dir.push_back('{64'h8000_0000, 64'hFFFF_FFFF, 1'b0, 1'b0, 0, 64'hFFFF_FFFF_8000_0000});
        dir.push_back('{64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b0, 0, 64'h0});
        dir.push_back('{64'hFFFF_FFFF, 64'd2, 1'b0, 1'b1, 0, 64'h0000_0000_7FFF_FFFF});
        dir.push_back('{64'd100, 64'd7, 1'b0, 1'b0, 5, 64'h0000_0000_0000_000E});
        dir.push_back('{64'hDEAD_BEEF_0000_0064, 64'h1234_5678_0000_0007, 1'b1, 1'b0, 2,
                        64'h0000_0000_0000_0002});
        foreach (dir[i]) begin
            issue(dir[i].s1, dir[i].s2, dir[i].rem, dir[i].uns, dir[i].hold, dir[i].eres,
                  ref_lat(dir[i].s1, dir[i].s2, dir[i].uns), 1'b1);
            wait_idle();
        end

`ifdef YSYX_22050612_DIVW_EARLYOUT_EN
        early_lat = 1;
`else
        early_lat = 33;
`endif
        issue(64'd3, 64'd10, 1'b0, 1'b0, 0, 64'd0, early_lat, 1'b1);
        wait_idle();
        issue(64'hFFFF_FFFF_FFFF_FFFD, 64'd10, 1'b1, 1'b0, 0, 64'hFFFF_FFFF_FFFF_FFFD,
              early_lat, 1'b1);
        wait_idle();

        // Kill in the tenth CALC cycle: nothing may come out.
        issue(64'd1000, 64'd3, 1'b0, 1'b0, 0, 64'd0, 0, 1'b0);
        repeat (9) @(posedge clk);
        #1 bus.kill = 1'b1;
        @(posedge clk);
        #1 bus.kill = 1'b0;
        @(negedge clk);
        check_idle_outputs("kill");
        repeat (40) @(negedge clk);
        chk("kill_no_valid", 64'(bus.out_valid), 64'd0);

        // Reset in the middle of CALC.
        issue(64'd12345, 64'd17, 1'b1, 1'b1, 0, 64'd0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("midreset");
        chk("midreset_result", bus.result, 64'd0);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0: begin s1 = {$urandom, $urandom}; s2 = {$urandom, 32'd0}; end
                1: begin s1 = 64'($urandom_range(0, 50)); s2 = 64'($urandom_range(1, 60)); end
                2: begin s1 = {$urandom, $urandom}; s2 = 64'($urandom_range(1, 9)); end
                3: begin s1 = {$urandom, 32'h8000_0000}; s2 = {$urandom, $urandom}; end
                default: begin s1 = {$urandom, $urandom}; s2 = {$urandom, $urandom}; end
            endcase
            run_op(s1, s2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3));
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ysyx_22050612_divw_seq.md
YSYX_22050612_DIVW_SEQ -- requirements
Module: ysyx_22050612_divw_seq

Interface
REQ-001 clk  input  1  sole clock; all state updates on posedge clk.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  operand set offered this cycle.
REQ-004 in_ready  output  1  block can accept an operand set; high only in IDLE.
REQ-005 op_rem  input  1  1 selects remainder (remw/remuw); 0 selects quotient (divw/divuw).
REQ-006 op_unsigned  input  1  1 selects unsigned 32-bit operation; 0 selects signed.
REQ-007 src1  input  64  dividend; only bits [31:0] are used.
REQ-008 src2  input  64  divisor; only bits [31:0] are used.
REQ-009 kill  input  1  pipeline flush; aborts any operation in flight.
REQ-010 out_valid  output  1  result is valid; high only in DONE.
REQ-011 out_ready  input  1  consumer accepts the result this cycle.
REQ-012 result  output  64  32-bit quotient or remainder, sign-extended from bit 31 to 64 bits.
REQ-013 busy  output  1  high in CALC or DONE; used by the pipeline to stall issue.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-015 The accept condition SHALL be in_valid & in_ready & !kill; operands, op_rem and op_unsigned are latched on that edge.
REQ-016 For a signed operation, the block SHALL take operand magnitudes and SHALL record quotient sign = sign1 XOR sign2 and remainder sign = sign1.
REQ-017 On accept, divisor[31:0]==0 SHALL go to DONE next cycle with quotient 0xFFFFFFFF and remainder dividend[31:0].
REQ-018 On a signed accept, dividend 0x80000000 with divisor 0xFFFFFFFF SHALL go to DONE next cycle with quotient 0x80000000 and remainder 0.
REQ-019 Any other accept SHALL enter CALC and run restoring division, one quotient bit per cycle, for exactly 32 CALC cycles, then go to DONE.
REQ-020 Latency SHALL be 33 cycles from the accept edge to the first out_valid cycle for the iterative path, and 1 cycle for the special cases.
REQ-021 On entry to DONE, sign fix-up SHALL be applied: negate the quotient and/or remainder per REQ-016, signed ops only.
REQ-022 In DONE, result SHALL be held stable until out_valid & out_ready, after which the FSM returns to IDLE on the next edge.
REQ-023 in_ready SHALL be 0 in the handoff cycle, so no new accept can occur in the same cycle as a result handoff.
REQ-024 kill asserted in any state SHALL force IDLE on the next edge, drop out_valid, and discard the result; kill has priority over accept and handoff.
REQ-025 The iteration counter SHALL be 6 bits and SHALL never wrap during CALC.

Reset
REQ-026 With rst high at a clock edge, state SHALL be IDLE, the counter 0 and all datapath registers 0.
REQ-027 The reset output values SHALL be in_ready=1, out_valid=0, busy=0 and result=0.
REQ-028 rst SHALL take precedence over kill and all handshakes, including mid-CALC.

Configuration
REQ-029 The macro YSYX_22050612_DIVW_EARLYOUT_EN SHALL control the early-out path.
REQ-030 When YSYX_22050612_DIVW_EARLYOUT_EN is defined, an accept with |dividend| < |divisor| (magnitudes, nonzero divisor) SHALL go directly to DONE next cycle with quotient 0 and remainder equal to the dividend, after sign fix-up.
REQ-031 When YSYX_22050612_DIVW_EARLYOUT_EN is undefined, such operands SHALL take the full 32-cycle path; results SHALL be bit-identical either way.

Verification
REQ-032 divw 100/7 -> result 0x000000000000000E after 33 cycles; remw 100/7 -> 0x0000000000000002.
REQ-033 divw -7/2 (src1 0xFFFFFFFFFFFFFFF9) -> 0xFFFFFFFFFFFFFFFD; remw same operands -> 0xFFFFFFFFFFFFFFFF.
REQ-034 divw 5/0 -> 0xFFFFFFFFFFFFFFFF after 1 cycle; remw 5/0 -> 0x0000000000000005.
REQ-035 Signed 0x80000000 / 0xFFFFFFFF: divw -> 0xFFFFFFFF80000000, remw -> 0; divuw 0xFFFFFFFF/2 -> 0x000000007FFFFFFF.
REQ-036 Hold out_ready low for 5 cycles in DONE -> result and out_valid stable and in_ready=0 throughout; kill pulsed at CALC cycle 10 -> IDLE next cycle, out_valid never asserted.
REQ-037 With YSYX_22050612_DIVW_EARLYOUT_EN defined, divw 3/10 -> out_valid 1 cycle after accept with result 0; undefined -> 33 cycles, same result.
